// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
// Front end of the UART receiver. Synchronises the raw serial line, detects
// the start-bit falling edge, runs the oversampling edge counter and the
// frame bit counter, and presents a 3-sample majority vote of each bit to the
// downstream deserializer together with start-glitch / stop-error flags.
//
// Ports:
//   CLK          oversampling clock
//   RST          asynchronous active-low reset
//   RX_IN        raw serial line (idle high, asynchronous to CLK)
//   En           frame-in-progress enable from the RX FSM
//   Prescale     oversampling ratio (8, 16 or 32)
//   Par_En       parity bit present in the frame
//   start_edge   one-cycle pulse on a synchronised 1->0 line transition
//   edge_count   oversampling edge within the current bit, 0..Prescale-1
//   bit_count    bit index within the frame (0 = start, last = stop)
//   sampled_bit  majority-voted value of the current bit
//   sample_valid one-cycle pulse when sampled_bit updates
//   start_glitch one-cycle pulse when the start bit votes 1
//   stop_err     one-cycle pulse when the stop bit votes 0
//   frame_done   one-cycle pulse after the last edge of the stop bit
module uart_rx_sampler #(
  parameter int Data_Width = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic       En,
  input  logic [5:0] Prescale,
  input  logic       Par_En,
  output logic       start_edge,
  output logic [5:0] edge_count,
  output logic [3:0] bit_count,
  output logic       sampled_bit,
  output logic       sample_valid,
  output logic       start_glitch,
  output logic       stop_err,
  output logic       frame_done
);

  // Stop index without parity is Data_Width+1; parity adds one more bit.
  localparam logic [3:0] STOP_BASE = 4'(Data_Width + 1);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // rx_sync_r is the second synchroniser stage (the line value rx_s).
  logic       rx_meta_r, rx_sync_r, rx_prev_r;
  logic [5:0] edge_cnt_r;
  logic [3:0] bit_cnt_r;
  logic       samp0_r, samp1_r;
  logic       sampled_bit_r, sample_valid_r, start_edge_r;
  logic       start_glitch_r, stop_err_r, frame_done_r;

  logic [5:0] presc_m1_s, half_s, half_m1_s, half_p1_s;
  logic [3:0] stop_idx_s;
  logic       edge_last_s, bit_last_s, vote_point_s, vote_s;
  logic [5:0] edge_nxt_s;
  logic [3:0] bit_nxt_s;
  logic       valid_nxt_s, glitch_nxt_s, stop_err_nxt_s, done_nxt_s;

  assign presc_m1_s   = Prescale - 6'd1;
  assign half_s       = {1'b0, Prescale[5:1]};
  assign half_m1_s    = half_s - 6'd1;
  assign half_p1_s    = half_s + 6'd1;
  assign stop_idx_s   = STOP_BASE + {3'b000, Par_En};
  assign edge_last_s  = (edge_cnt_r == presc_m1_s);
  assign bit_last_s   = (bit_cnt_r == stop_idx_s);
  assign vote_point_s = (edge_cnt_r == half_p1_s);
  // The third sample is the live line value at h+1; it goes straight into the vote.
  assign vote_s       = maj3(samp0_r, samp1_r, rx_sync_r);

  // Counter next-state and pulse decode; En low clears counters and blocks pulses.
  always_comb begin
    edge_nxt_s     = 6'd0;
    bit_nxt_s      = 4'd0;
    valid_nxt_s    = 1'b0;
    glitch_nxt_s   = 1'b0;
    stop_err_nxt_s = 1'b0;
    done_nxt_s     = 1'b0;
    if (!En) begin
      edge_nxt_s = 6'd0;
      bit_nxt_s  = 4'd0;
    end else if (edge_last_s) begin
      edge_nxt_s = 6'd0;
      if (bit_last_s) begin
        bit_nxt_s  = 4'd0;
        done_nxt_s = 1'b1;
      end else begin
        bit_nxt_s  = bit_cnt_r + 4'd1;
        done_nxt_s = 1'b0;
      end
    end else begin
      edge_nxt_s = edge_cnt_r + 6'd1;
      bit_nxt_s  = bit_cnt_r;
    end
    if (En && vote_point_s) begin
      valid_nxt_s    = 1'b1;
      glitch_nxt_s   = (bit_cnt_r == 4'd0) && vote_s;
      stop_err_nxt_s = bit_last_s && !vote_s;
    end else begin
      valid_nxt_s    = 1'b0;
      glitch_nxt_s   = 1'b0;
      stop_err_nxt_s = 1'b0;
    end
  end

  // Line synchroniser and start-edge detector (independent of En).
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_meta_r    <= 1'b1;
      rx_sync_r    <= 1'b1;
      rx_prev_r    <= 1'b1;
      start_edge_r <= 1'b0;
    end else begin
      rx_meta_r    <= RX_IN;
      rx_sync_r    <= rx_meta_r;
      rx_prev_r    <= rx_sync_r;
      start_edge_r <= rx_prev_r & ~rx_sync_r;
    end
  end

  // Edge/bit counters and registered frame pulses.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt_r     <= 6'd0;
      bit_cnt_r      <= 4'd0;
      sample_valid_r <= 1'b0;
      start_glitch_r <= 1'b0;
      stop_err_r     <= 1'b0;
      frame_done_r   <= 1'b0;
    end else begin
      edge_cnt_r     <= edge_nxt_s;
      bit_cnt_r      <= bit_nxt_s;
      sample_valid_r <= valid_nxt_s;
      start_glitch_r <= glitch_nxt_s;
      stop_err_r     <= stop_err_nxt_s;
      frame_done_r   <= done_nxt_s;
    end
  end

  // Mid-bit sample capture and vote register; values are retained while En is low.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      samp0_r       <= 1'b1;
      samp1_r       <= 1'b1;
      sampled_bit_r <= 1'b1;
    end else begin
      if (En && (edge_cnt_r == half_m1_s)) begin
        samp0_r <= rx_sync_r;
      end
      if (En && (edge_cnt_r == half_s)) begin
        samp1_r <= rx_sync_r;
      end
      if (valid_nxt_s) begin
        sampled_bit_r <= vote_s;
      end
    end
  end

  assign start_edge   = start_edge_r;
  assign edge_count   = edge_cnt_r;
  assign bit_count    = bit_cnt_r;
  assign sampled_bit  = sampled_bit_r;
  assign sample_valid = sample_valid_r;
  assign start_glitch = start_glitch_r;
  assign stop_err     = stop_err_r;
  assign frame_done   = frame_done_r;

endmodule
